shift_left_iter: RTL and testbench

//  Iterative logical left shifter with valid/ready handshakes on both sides; the inverse-direction

---
 rtl/cordic_pkg.sv | 17 +
 rtl/shl1_stage.sv | 17 +
 rtl/shift_left_iter.sv | 123 ++++++++++++
 tb/tb_shift_left_iter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC datapath blocks.
// Contents:
//   state_e      - control state encoding of the iterative shifter (IDLE/SHIFT/DONE)
//   SHL_WIDTH    - default data width of the shifter operands
//   SHL_SHAMT_W  - default width of the run-time shift amount
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned SHL_WIDTH   = 4;
  localparam int unsigned SHL_SHAMT_W = 2;

endpackage

// File: rtl/shl1_stage.sv
// Combinational single-bit logical left shift.
// Ports:
//   a_i      in  WIDTH  word to shift
//   y_o      out WIDTH  a_i shifted left by one, LSB filled with 0
//   carry_o  out 1      bit shifted out of the MSB
module shl1_stage #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o,
  output logic             carry_o
);

  assign y_o     = {a_i[WIDTH-2:0], 1'b0};
  assign carry_o = a_i[WIDTH-1];

endmodule

// File: rtl/shift_left_iter.sv
// Iterative logical left shifter, one bit per clock, valid/ready on both sides.
// Accepts an operand in IDLE, shifts it shamt times in SHIFT, then holds the
// result in DONE until the consumer takes it. ovf flags any 1 shifted out.
// Optional feature: define SHL_SATURATE_EN to saturate z to all ones in DONE
// whenever ovf is set (ovf is still reported).
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset
//   in_valid   in   1        operand offered
//   in_ready   out  1        operand can be accepted (IDLE, not in reset)
//   x          in   WIDTH    operand, sampled on accept
//   shamt      in   SHAMT_W  left-shift amount, sampled on accept
//   out_valid  out  1        z/ovf valid (DONE)
//   out_ready  in   1        consumer takes result
//   z          out  WIDTH    shifted result
//   ovf        out  1        a 1 bit was shifted out of the MSB
module shift_left_iter
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH   = SHL_WIDTH,
  parameter int unsigned SHAMT_W = SHL_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   z,
  output logic               ovf
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   shl_word_s;
  logic               shl_carry_s;

  shl1_stage #(
    .WIDTH (WIDTH)
  ) u_shl1 (
    .a_i     (data_q),
    .y_o     (shl_word_s),
    .carry_o (shl_carry_s)
  );

  // State, data, count and overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= {WIDTH{1'b0}};
      count_q <= {SHAMT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        // in_ready is only low in IDLE while rst is high, and the registers
        // are held by reset then, so in_valid alone marks an accept here.
        if (in_valid) begin
          data_d  = x;
          count_d = shamt;
          ovf_d   = 1'b0;
          if (shamt == {SHAMT_W{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        data_d  = shl_word_s;
        ovf_d   = ovf_q | shl_carry_s;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign ovf       = ovf_q;

`ifdef SHL_SATURATE_EN
  // Unsigned saturation only once the result is presented.
  assign z = (out_valid && ovf_q) ? {WIDTH{1'b1}} : data_q;
`else
  assign z = data_q;
`endif

endmodule

// File: tb/tb_shift_left_iter.sv
// Directed self-checking bench for shift_left_iter (WIDTH=4, SHAMT_W=2).
module tb_shift_left_iter;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] x;
  logic [1:0] shamt;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] z;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  shift_left_iter #(
    .WIDTH   (4),
    .SHAMT_W (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation: offer, measure latency, check result, hold, release.
  task automatic run_op(input string tag, input logic [3:0] xv, input logic [1:0] sv,
                        input int hold, input logic [3:0] exp_z, input logic exp_ovf);
    int edges;
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    x         = xv;
    shamt     = sv;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x        = 4'hF;
    shamt    = 2'd3;
    edges    = 1;
    while (!out_valid && edges < 16) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'(sv) + 32'd1);
    check({tag, " z"}, 32'(z), 32'(exp_z));
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      // a new operand offered while busy must be ignored
      in_valid = 1'b1;
      x        = 4'b0110;
      shamt    = 2'd1;
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold z"}, 32'(z), 32'(exp_z));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " consumed out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " consumed in_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] rt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = 4'b0000;
    shamt     = 2'd0;
    out_ready = 1'b0;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset z", 32'(z), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    // 1: two-bit shift, consumer always ready
    run_op("t1", 4'b0011, 2'd2, 0, 4'b1100, 1'b0);
    // 2: MSB shifted out
`ifdef SHL_SATURATE_EN
    run_op("t2", 4'b1010, 2'd1, 0, 4'b1111, 1'b1);
`else
    run_op("t2", 4'b1010, 2'd1, 0, 4'b0100, 1'b1);
`endif
    // 3: zero shift amount passes x through
    run_op("t3", 4'b1001, 2'd0, 0, 4'b1001, 1'b0);
    // 4: maximum shift with 5 cycles of back-pressure
    run_op("t4", 4'b0001, 2'd3, 5, 4'b1000, 1'b0);
    // 4b: next operand accepted right after release
    run_op("t4b", 4'b0101, 2'd1, 1, 4'b1010, 1'b0);

    // 5: reset in the middle of a shift
    @(negedge clk);
    in_valid = 1'b1;
    x        = 4'b0111;
    shamt    = 2'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5 rst out_valid", 32'(out_valid), 32'd0);
    check("t5 rst z", 32'(z), 32'd0);
    check("t5 rst in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5 release in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("t5 no stale out_valid", 32'(out_valid), 32'd0);
    end

    // 6: round trip through a fixed right shift by 2
    run_op("t6", 4'b0011, 2'd2, 1, 4'b1100, 1'b0);
    rt = 4'b1100;
    rt = rt >> 2;
    check("t6 round trip", 32'(rt), 32'b0011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
